ex_div: RTL and testbench
=========================

# ex_div

Iterative RV32M divide/remainder unit inside the execute stage. It consumes the operands and ALU op that the ID/EX register presents to EX (DIV, DIVU, REM, REMU) and computes the result with a radix-2 restoring algorithm, one bit per cycle. While it works it raises a stall request to the pipeline control, which holds ID/EX and earlier stages. It returns a registered result with a one-cycle done pulse that EX muxes onto its write-back data.

## Interface
- WIDTH, 32, operand/result width; the iteration counter is clog2(WIDTH)+1 bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start_i  in  1  EX holds a divide-class op; held high by EX for as long as the op stays in EX.
- op_i  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start_i.
- dividend_i  in  WIDTH  rs1 value.
- divisor_i  in  WIDTH  rs2 value.
- cancel_i  in  1  EX flush (branch/trap); aborts any operation in progress.
- result_o  out  WIDTH  quotient or remainder; valid while done_o=1.
- done_o  out  1  one-cycle pulse: result_o is valid.
- busy_o  out  1  state != IDLE.
- stall_req_o  out  1  combinational stall request to pipeline control.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, start_i=1, cancel_i=0: latch op, the sign flags and the operand magnitudes.
  - DIVU/REMU take the operands unsigned.
  - DIV/REM take absolute values; the quotient is negated if the operand signs differ, and the remainder takes the dividend's sign.
- Special cases go directly IDLE->DONE on the next edge, with the result computed at that edge:
  - divisor=0: quotient=all ones; remainder=dividend (unmodified).
  - DIV/REM with dividend=0x80000000 and divisor=0xFFFFFFFF: quotient=0x80000000; remainder=0.
- Otherwise IDLE->CALC, with rem=0, quo=|dividend| and cnt=0.
- Each CALC edge performs one iteration:
  - shifted = {rem[W-1:0], quo[W-1]}.
  - trial = shifted - {1'b0, |divisor|}, computed W+1 bits wide.
  - If trial does not borrow: rem=trial and quo={quo[W-2:0],1}.
  - Otherwise: rem=shifted and quo={quo[W-2:0],0}.
  - cnt increments.
- On the edge where cnt reaches WIDTH-1, go CALC->DONE and load result_o with the sign-corrected quo or rem, according to op.
- DONE: done_o=1 for exactly one cycle, then DONE->IDLE unconditionally. start_i still being high in DONE (same instruction) does not restart the unit.
- stall_req_o = (state==IDLE & start_i & ~cancel_i) | (state==CALC & ~cancel_i). It is 0 in DONE so the pipeline advances on that edge. It is 0 while rst is high.
- cancel_i=1 in any state: the next state is IDLE, done_o stays 0 and result_o holds its value. cancel_i takes priority over start_i.

## Timing
- Reset values: state=IDLE, result_o=0, done_o=0, busy_o=0, stall_req_o=0, internal rem/quo/cnt=0.
- Normal op: start_i is seen at edge E0. CALC spans edges E1..E32, and the DONE cycle follows E32. That gives done_o high in cycle 33 after E0; the result is consumed at the 33rd edge after E0.
- Special case: done_o is high in the cycle after E0, so latency is 1.
- A back-to-back divide can start at the edge leaving DONE+1. The IDLE cycle after DONE is the accept cycle for the next op.
- Operands are latched only at E0. Later changes on dividend_i/divisor_i/op_i have no effect.
- Reset mid-operation: everything returns immediately to the reset values with no done pulse.

## Test plan
- DIV: 100/7 -> stall_req_o high for 33 cycles; done_o pulses once; result_o=14. Repeat with REM -> 2.
- Signed: REM -7,2 -> 0xFFFFFFFF (-1). DIV -7,2 -> 0xFFFFFFFD (-3). DIVU 0xFFFFFFF9,2 -> 0x7FFFFFFC.
- Zero divisor: DIVU 5,0 -> 0xFFFFFFFF and REMU 5,0 -> 5. Each gives done_o one cycle after start with no CALC.
- Overflow: DIV 0x80000000,0xFFFFFFFF -> 0x80000000, latency 1. REM of the same operands -> 0.
- Abort: assert cancel_i at CALC iteration 10. Check state=IDLE on the next edge with no done_o. Then start DIVU 9,3 -> 3 after 33 cycles.
- Reset: assert rst mid-CALC. Check outputs drop to their reset values immediately; after release, a new DIV 20,4 -> 5.

Source files
------------

// File: rtl/ex_div.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit for the execute stage.
// Radix-2 restoring division that produces one quotient bit per cycle and stalls the pipeline while it runs.
module ex_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             cancel_i,
    output logic [WIDTH-1:0] result_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             stall_req_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [1:0]       op_q;
    logic             neg_quo;
    logic             neg_rem;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [CNT_W-1:0] cnt;

    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v,
                                                 input logic take_signed);
        logic signed [WIDTH-1:0] neg_v;
        neg_v = -v;
        if (take_signed && v[WIDTH-1])
            return $unsigned(neg_v);
        return $unsigned(v);
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                    input logic neg);
        return neg ? (~mag + 1'b1) : mag;
    endfunction

    // Operand decode for the accept cycle
    logic                    is_signed;
    logic signed [WIDTH-1:0] dividend_s;
    logic signed [WIDTH-1:0] divisor_s;
    logic                    dvd_neg;
    logic                    dvs_neg;
    logic [WIDTH-1:0]        dvd_abs;
    logic [WIDTH-1:0]        dvs_abs;
    logic                    div_zero;
    logic                    overflow;
    logic                    special;
    logic [WIDTH-1:0]        special_res;
    logic                    accept;

    always_comb begin
        is_signed   = ~op_i[0];
        dividend_s  = $signed(dividend_i);
        divisor_s   = $signed(divisor_i);
        dvd_neg     = is_signed & dividend_i[WIDTH-1];
        dvs_neg     = is_signed & divisor_i[WIDTH-1];
        dvd_abs     = abs_val(dividend_s, is_signed);
        dvs_abs     = abs_val(divisor_s, is_signed);
        div_zero    = (divisor_i == '0);
        overflow    = is_signed && (dividend_i == MIN_NEG) && (divisor_i == '1);
        special     = div_zero | overflow;
        special_res = '0;
        if (div_zero)
            special_res = op_i[1] ? dividend_i : '1;
        else if (overflow)
            special_res = op_i[1] ? '0 : MIN_NEG;
        accept      = (state == IDLE) & start_i & ~cancel_i;
    end

    // One restoring iteration: shift in the next dividend bit, try to subtract
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             borrow;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] final_res;
    logic             last_iter;

    always_comb begin
        shifted   = {rem, quo[WIDTH-1]};
        trial     = {1'b0, shifted} - {2'b00, dvs_mag};
        borrow    = trial[WIDTH+1];
        rem_nxt   = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nxt   = {quo[WIDTH-2:0], ~borrow};
        final_res = op_q[1] ? apply_sign(rem_nxt, neg_rem) : apply_sign(quo_nxt, neg_quo);
        last_iter = (cnt == LAST_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cancel_i) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (start_i) state_nxt = special ? DONE : CALC;
                CALC: if (last_iter) state_nxt = DONE;
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o      = (state != IDLE);
        done_o      = (state == DONE);
        stall_req_o = ~rst & ~cancel_i & (((state == IDLE) & start_i) | (state == CALC));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            dvs_mag  <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            result_o <= '0;
        end else if (accept) begin
            op_q    <= op_i;
            neg_quo <= dvd_neg ^ dvs_neg;
            neg_rem <= dvd_neg;
            dvs_mag <= dvs_abs;
            rem     <= '0;
            quo     <= dvd_abs;
            cnt     <= '0;
            if (special)
                result_o <= special_res;
        end else if ((state == CALC) && !cancel_i) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 1'b1;
            if (last_iter)
                result_o <= final_res;
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: results, latency, stall length, cancel and reset behaviour.
module tb_ex_div;

    localparam int W = 32;
    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [1:0]   op_i;
    logic [W-1:0] dividend_i;
    logic [W-1:0] divisor_i;
    logic         cancel_i;
    logic [W-1:0] result_o;
    logic         done_o;
    logic         busy_o;
    logic         stall_req_o;

    int errors = 0;
    int checks = 0;

    ex_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .cancel_i    (cancel_i),
        .result_o    (result_o),
        .done_o      (done_o),
        .busy_o      (busy_o),
        .stall_req_o (stall_req_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the unit idle; scrambles operands after the accept edge.
    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat);
        int lat;
        int stalls;
        lat = 0;
        stalls = 0;
        op_i = op;
        dividend_i = a;
        divisor_i = b;
        start_i = 1'b1;
        #1;
        while (lat < 100) begin
            if (stall_req_o) stalls++;
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                op_i = ~op;
                dividend_i = ~a;
                divisor_i = 32'd3;
            end
            if (done_o) break;
        end
        check({name, ".latency"}, W'(lat), W'(exp_lat));
        check({name, ".stalls"}, W'(stalls), W'(exp_lat));
        check({name, ".result"}, result_o, exp);
        @(negedge clk);
        check({name, ".single_done"}, {31'b0, done_o | busy_o}, 32'd0);
        start_i = 1'b0;
    endtask

    initial begin
        int late_done;
        rst = 1'b1;
        start_i = 1'b1;
        cancel_i = 1'b0;
        op_i = OP_DIV;
        dividend_i = 32'd100;
        divisor_i = 32'd7;
        #1;
        check("reset.result", result_o, 32'd0);
        check("reset.done", {31'b0, done_o}, 32'd0);
        check("reset.busy", {31'b0, busy_o}, 32'd0);
        check("reset.stall", {31'b0, stall_req_o}, 32'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd14, 33);
        run_op("rem_100_7", OP_REM, 32'd100, 32'd7, 32'd2, 33);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("divu_big_2", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);
        run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Abort at CALC iteration 10
        op_i = OP_DIVU;
        dividend_i = 32'd100;
        divisor_i = 32'd7;
        start_i = 1'b1;
        @(negedge clk);
        repeat (9) @(negedge clk);
        check("abort.busy_before", {31'b0, busy_o}, 32'd1);
        cancel_i = 1'b1;
        start_i = 1'b0;
        #1;
        check("abort.stall_during_cancel", {31'b0, stall_req_o}, 32'd0);
        @(negedge clk);
        check("abort.busy_after", {31'b0, busy_o}, 32'd0);
        check("abort.done_after", {31'b0, done_o}, 32'd0);
        cancel_i = 1'b0;
        late_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) late_done++;
        end
        check("abort.no_late_done", W'(late_done), 32'd0);

        // Cancel wins over start while idle
        start_i = 1'b1;
        cancel_i = 1'b1;
        #1;
        check("cancel_prio.stall", {31'b0, stall_req_o}, 32'd0);
        @(negedge clk);
        check("cancel_prio.busy", {31'b0, busy_o}, 32'd0);
        start_i = 1'b0;
        cancel_i = 1'b0;
        @(negedge clk);

        run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

        // Asynchronous reset in the middle of CALC
        op_i = OP_DIV;
        dividend_i = 32'd100;
        divisor_i = 32'd7;
        start_i = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_mid.busy_before", {31'b0, busy_o}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid.result", result_o, 32'd0);
        check("rst_mid.done", {31'b0, done_o}, 32'd0);
        check("rst_mid.busy", {31'b0, busy_o}, 32'd0);
        check("rst_mid.stall", {31'b0, stall_req_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start_i = 1'b0;
        @(negedge clk);

        run_op("div_20_4", OP_DIV, 32'd20, 32'd4, 32'd5, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
